// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared USB TX state encodings and CRC16 constants
package usb_tx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CRC} tx_crc_state_t;
  localparam logic [15:0] USB_CRC16_POLY = 16'h8005;
  localparam logic [15:0] USB_CRC16_SEED = 16'hFFFF;
endpackage

// File: rtl/usb_tx_crc16_gen_if.sv
// usb_tx_crc16_gen_if: serializer-side control/data and stuffer-side outputs of the CRC16 generator
interface usb_tx_crc16_gen_if;
  logic clear, start, shift_enable, d_in, payload_end;
  logic d_out, crc_active, crc_done, busy;
  modport master(output clear, start, shift_enable, d_in, payload_end,
                 input d_out, crc_active, crc_done, busy);
  modport slave(input clear, start, shift_enable, d_in, payload_end,
                output d_out, crc_active, crc_done, busy);
endinterface

// File: rtl/usb_tx_crc16_gen_lfsr.sv
// usb_crc16_lfsr: CRC16 register; feedback shift in DATA, ones-fill shift while draining
module usb_crc16_lfsr import usb_tx_pkg::*; #(
  parameter logic [15:0] CRC_POLY = USB_CRC16_POLY,
  parameter logic [15:0] CRC_SEED = USB_CRC16_SEED
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load_seed,
  input  logic        shift,
  input  logic        din,
  input  logic        invert_fill,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) q <= CRC_SEED;
    else if (load_seed) q <= CRC_SEED;
    else if (shift)
      q <= invert_fill ? {q[14:0], 1'b1}
                       : {q[14:0], 1'b0} ^ ((din ^ q[15]) ? CRC_POLY : 16'h0000);
endmodule

// File: rtl/usb_tx_crc16_gen.sv
// usb_tx_crc16_gen: passes payload bits through, then appends the complemented USB CRC16 MSB first
module usb_tx_crc16_gen import usb_tx_pkg::*; #(
  parameter logic [15:0] CRC_POLY = USB_CRC16_POLY,
  parameter logic [15:0] CRC_SEED = USB_CRC16_SEED
) (
  input logic               clk,
  input logic               n_rst,
  usb_tx_crc16_gen_if.slave bus
);
  tx_crc_state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        done, done_n, load, shift, fill;
  logic [15:0] crc;
  logic        unused_crc;
  usb_crc16_lfsr #(.CRC_POLY(CRC_POLY), .CRC_SEED(CRC_SEED)) lfsr (
    .clk(clk), .n_rst(n_rst), .load_seed(load), .shift(shift),
    .din(bus.d_in), .invert_fill(fill), .q(crc)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    fill    = 1'b0;
    if (bus.clear || bus.start) begin
      state_n = bus.clear ? IDLE : DATA;
      cnt_n   = '0;
      load    = 1'b1;
    end else if (state == DATA) begin
      shift = bus.shift_enable;
      if (bus.payload_end) begin
        state_n = CRC;
        cnt_n   = '0;
      end
    end else if (state == CRC && bus.shift_enable) begin
      shift = 1'b1;
      fill  = 1'b1;
      cnt_n = cnt + 4'd1;
      if (cnt == 4'd15) begin
        state_n = IDLE;
        load    = 1'b1;
        done_n  = 1'b1;
      end
    end
  end
  // CRC bits come from the register only, so d_out cannot glitch between strobes
  assign bus.d_out      = (state == DATA) ? bus.d_in : (state == CRC) ? ~crc[15] : 1'b1;
  assign bus.crc_active = (state == CRC);
  assign bus.busy       = (state != IDLE);
  assign bus.crc_done   = done;
  assign unused_crc     = ^crc[14:0];
endmodule

// File: tb/tb_usb_tx_crc16_gen.sv
// tb_usb_tx_crc16_gen: directed checks of the TX CRC16 generator against a reflected bit-serial model
module tb_usb_tx_crc16_gen;
  logic clk = 1'b0, n_rst = 1'b0;
  int total = 0, bad = 0, pt_bad = 0;
  logic [15:0] m = 16'hFFFF;
  logic [15:0] g0, g1, g;
  logic [71:0] ascii = "123456789";
  int done_seen;
  usb_tx_crc16_gen_if bus();
  usb_tx_crc16_gen dut(.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic m_bit(input logic b);
    m = (m[0] ^ b) ? ((m >> 1) ^ 16'hA001) : (m >> 1);
  endtask
  task automatic send_bit(input logic b, input logic pe, input int ms);
    repeat (ms > 0 ? $urandom_range(ms, 0) : 0) tick;
    bus.d_in = b;
    bus.shift_enable = 1'b1;
    bus.payload_end = pe;
    #1;
    if (bus.d_out !== b) pt_bad++;
    tick;
    bus.shift_enable = 1'b0;
    bus.payload_end = 1'b0;
    m_bit(b);
  endtask
  task automatic send_byte(input logic [7:0] v, input int ms);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0, ms);
  endtask
  task automatic pulse_start;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    m = 16'hFFFF;
    pt_bad = 0;
  endtask
  task automatic pulse_end;
    bus.payload_end = 1'b1;
    tick;
    bus.payload_end = 1'b0;
  endtask
  task automatic crc_bits(input string tag, input int ms, output logic [15:0] got);
    int early = 0;
    for (int i = 0; i < 16; i++) begin
      repeat (ms > 0 ? $urandom_range(ms, 0) : 0) tick;
      if (bus.crc_done || !bus.crc_active) early++;
      got[i] = bus.d_out;
      bus.shift_enable = 1'b1;
      tick;
      bus.shift_enable = 1'b0;
    end
    chk({tag, "_active"}, early, 0);
    chk({tag, "_done"}, bus.crc_done, 1);
    chk({tag, "_idle"}, bus.busy, 0);
    tick;
    chk({tag, "_done1"}, bus.crc_done, 0);
  endtask
  task automatic check_pkt(input string tag, input int ms, output logic [15:0] got);
    logic [15:0] exp = ~m;
    crc_bits(tag, ms, got);
    chk({tag, "_crc"}, got, exp);
    chk({tag, "_pass"}, pt_bad, 0);
    for (int i = 0; i < 16; i++) m_bit(got[i]);
    chk({tag, "_resid"}, m, 16'hB001);
  endtask

  initial begin
    bus.clear = 0; bus.start = 0; bus.shift_enable = 0; bus.d_in = 0; bus.payload_end = 0;
    #3;
    chk("rst_dout", bus.d_out, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_active", bus.crc_active, 0);
    chk("rst_done", bus.crc_done, 0);
    #10 n_rst = 1'b1;
    tick;
    pulse_start;
    chk("empty_busy", bus.busy, 1);
    pulse_end;
    chk("empty_active", bus.crc_active, 1);
    check_pkt("empty", 0, g);
    chk("empty_zero", g, 16'h0000);
    pulse_start;
    for (int i = 0; i < 9; i++) send_byte(ascii[71-8*i -: 8], 0);
    pulse_end;
    check_pkt("ascii", 0, g);
    chk("ascii_ref", g, 16'hB4C8);
    pulse_start;
    for (int i = 0; i < 4; i++) send_byte(8'(i), 0);
    pulse_end;
    check_pkt("p0123", 0, g0);
    pulse_start;
    for (int i = 0; i < 4; i++) send_byte(8'(i), 7);
    pulse_end;
    check_pkt("stall", 7, g1);
    chk("stall_same", g1, g0);
    pulse_start;
    send_byte(8'hA5, 0);
    pulse_end;
    for (int i = 0; i < 7; i++) begin
      bus.shift_enable = 1'b1;
      tick;
      bus.shift_enable = 1'b0;
    end
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.shift_enable = 1'b1;
    tick;
    bus.clear = 1'b0;
    bus.start = 1'b0;
    bus.shift_enable = 1'b0;
    chk("clr_busy", bus.busy, 0);
    chk("clr_active", bus.crc_active, 0);
    chk("clr_dout", bus.d_out, 1);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      done_seen += int'(bus.crc_done);
      bus.shift_enable = i[0];
      tick;
    end
    bus.shift_enable = 1'b0;
    chk("clr_nodone", done_seen, 0);
    pulse_start;
    for (int i = 0; i < 20; i++) send_bit(logic'((i * 7 + 3) % 5 > 1), 1'b0, 0);
    bus.start = 1'b1;
    bus.shift_enable = 1'b1;
    bus.d_in = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.shift_enable = 1'b0;
    m = 16'hFFFF;
    pt_bad = 0;
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_end;
    check_pkt("restart", 0, g);
    pulse_start;
    for (int i = 0; i < 7; i++) send_bit(logic'(8'hC3 >> i), 1'b0, 0);
    send_bit(1'b1, 1'b1, 0);
    chk("pe_se_active", bus.crc_active, 1);
    check_pkt("pe_se", 0, g);
    pulse_start;
    send_byte(8'h0F, 0);
    pulse_end;
    for (int i = 0; i < 3; i++) begin
      bus.shift_enable = 1'b1;
      tick;
      bus.shift_enable = 1'b0;
    end
    chk("mid_active", bus.crc_active, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_dout", bus.d_out, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_active", bus.crc_active, 0);
    chk("arst_done", bus.crc_done, 0);
    #7 n_rst = 1'b1;
    tick;
    chk("arst_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
